// File: rtl/regist_bank.sv
// regist_bank: a bank of CHANNELS accumulator/counter registers, each WIDTH bits
// wide with its own carry/extend bit E. On each clock edge, the channel addressed
// by sel executes one 3-bit op: hold, load, inc, dec, clear, shl, shr or
// complement. Every other channel and E bit holds its value.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-high; every channel takes LOAD_VALUE, every E is 0
//   op         operation applied to the selected channel
//   sel        channel select; a value >= CHANNELS changes nothing
//   DATA       load data
//   serial_in  fill bit for shl/shr
//   A          all channel values, channel i at [i*WIDTH +: WIDTH]
//   E          per-channel carry/extend bits
//   rd_data    value of channel sel (0 when sel is out of range), combinational
//   zero       bit i is set when channel i == 0, combinational
module regist_bank #(
   parameter int              WIDTH      = 16,
   parameter int              CHANNELS   = 4,
   parameter logic [WIDTH-1:0] LOAD_VALUE = '0,
   parameter bit              SATURATE   = 1'b0,
   localparam int             SW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [2:0]                op,
   input  logic [SW-1:0]             sel,
   input  logic [WIDTH-1:0]          DATA,
   input  logic                      serial_in,
   output logic [CHANNELS*WIDTH-1:0] A,
   output logic [CHANNELS-1:0]       E,
   output logic [WIDTH-1:0]          rd_data,
   output logic [CHANNELS-1:0]       zero
);

   localparam logic [2:0] OP_HOLD  = 3'b000;
   localparam logic [2:0] OP_LOAD  = 3'b001;
   localparam logic [2:0] OP_INC   = 3'b010;
   localparam logic [2:0] OP_DEC   = 3'b011;
   localparam logic [2:0] OP_CLEAR = 3'b100;
   localparam logic [2:0] OP_SHL   = 3'b101;
   localparam logic [2:0] OP_SHR   = 3'b110;
   localparam logic [2:0] OP_CMPL  = 3'b111;

   logic [CHANNELS-1:0][WIDTH-1:0] r_q;
   logic [CHANNELS-1:0]            e_q;
   logic [CHANNELS-1:0]            hit;
   logic [WIDTH-1:0]               cur_r;
   logic                           cur_e;
   logic [WIDTH-1:0]               nxt_r;
   logic                           nxt_e;

   // An out-of-range sel matches no channel, so cur_r stays 0. That zero is
   // also what rd_data returns in that case.
   always_comb begin
      hit   = '0;
      cur_r = '0;
      cur_e = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (sel == SW'(i)) begin
            hit[i] = 1'b1;
            cur_r  = r_q[i];
            cur_e  = e_q[i];
         end
      end
   end

   // One shared next-state datapath, steered to whichever channel is selected.
   always_comb begin
      nxt_r = cur_r;
      nxt_e = cur_e;
      case (op)
         OP_HOLD: ;
         OP_LOAD: nxt_r = DATA;
         OP_INC: begin
            if (SATURATE && (&cur_r)) begin
               nxt_e = 1'b1;
            end else begin
               {nxt_e, nxt_r} = {1'b0, cur_r} + (WIDTH+1)'(1);
            end
         end
         OP_DEC: begin
            if (cur_r == '0) begin
               nxt_e = 1'b1;
               nxt_r = SATURATE ? '0 : '1;
            end else begin
               nxt_e = 1'b0;
               nxt_r = cur_r - WIDTH'(1);
            end
         end
         OP_CLEAR: begin
            nxt_r = '0;
            nxt_e = 1'b0;
         end
         OP_SHL: begin
            nxt_e = cur_r[WIDTH-1];
            nxt_r = {cur_r[WIDTH-2:0], serial_in};
         end
         OP_SHR: begin
            nxt_e = cur_r[0];
            nxt_r = {serial_in, cur_r[WIDTH-1:1]};
         end
         OP_CMPL: nxt_r = ~cur_r;
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_q[i] <= LOAD_VALUE;
         end
         e_q <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (hit[i]) begin
               r_q[i] <= nxt_r;
               e_q[i] <= nxt_e;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         zero[i] = (r_q[i] == '0);
      end
   end

   assign A       = r_q;
   assign E       = e_q;
   assign rd_data = cur_r;

endmodule

// File: tb/tb_regist_bank.sv
// Bench for regist_bank. Two instances receive the same stimulus:
//   dut0: CHANNELS=4, LOAD_VALUE=5, wrapping inc/dec
//   dut1: CHANNELS=3, LOAD_VALUE=5, saturating inc/dec (sel=3 is out of range here)
// Every op pushes its hand-computed expectation into a queue. A monitor pops one
// entry just after each active edge and compares it with the outputs.
module tb_regist_bank;

   logic         clock;
   logic         reset;
   logic [2:0]   op;
   logic [1:0]   sel;
   logic [15:0]  DATA;
   logic         serial_in;
   logic [63:0]  A0;
   logic [3:0]   E0;
   logic [15:0]  rd0;
   logic [3:0]   z0;
   logic [47:0]  A1;
   logic [2:0]   E1;
   logic [15:0]  rd1;
   logic [2:0]   z1;

   int n_tests = 0;
   int n_fail  = 0;

   regist_bank #(.WIDTH(16), .CHANNELS(4), .LOAD_VALUE(16'h0005), .SATURATE(1'b0)) dut0 (
      .clock(clock), .reset(reset), .op(op), .sel(sel), .DATA(DATA),
      .serial_in(serial_in), .A(A0), .E(E0), .rd_data(rd0), .zero(z0));

   regist_bank #(.WIDTH(16), .CHANNELS(3), .LOAD_VALUE(16'h0005), .SATURATE(1'b1)) dut1 (
      .clock(clock), .reset(reset), .op(op), .sel(sel), .DATA(DATA),
      .serial_in(serial_in), .A(A1), .E(E1), .rd_data(rd1), .zero(z1));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string        name;
      logic [1:0]   sel;
      logic [15:0]  rd0;
      logic         e0;
      logic [15:0]  rd1;
      logic         e1;
      bit           chk_e1;
      bit           chk_a;
      logic [63:0]  a0;
      logic [3:0]   zz0;
      logic [47:0]  a1;
   } exp_t;

   exp_t sb[$];

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // The monitor samples 1 time unit after each rising edge. Stimulus only
   // changes on falling edges, so sel still names the channel the op went to.
   always @(posedge clock) begin
      if (sb.size() > 0) begin
         exp_t x;
         #1;
         x = sb.pop_front();
         cmp({x.name, " rd0"}, 64'(rd0), 64'(x.rd0));
         cmp({x.name, " e0"}, 64'(E0[x.sel]), 64'(x.e0));
         cmp({x.name, " rd1"}, 64'(rd1), 64'(x.rd1));
         if (x.chk_e1) cmp({x.name, " e1"}, 64'(E1[x.sel]), 64'(x.e1));
         if (x.chk_a) begin
            cmp({x.name, " A0"}, A0, x.a0);
            cmp({x.name, " zero0"}, 64'(z0), 64'(x.zz0));
            cmp({x.name, " A1"}, 64'(A1), 64'(x.a1));
         end
      end
   end

   task automatic step(input string nm, input logic [2:0] o, input logic [1:0] s,
                       input logic [15:0] d, input logic si,
                       input logic [15:0] x_rd0, input logic x_e0,
                       input logic [15:0] x_rd1, input logic x_e1, input bit ce1,
                       input bit ca = 1'b0, input logic [63:0] xa0 = '0,
                       input logic [3:0] xz0 = '0, input logic [47:0] xa1 = '0);
      exp_t x;
      @(negedge clock);
      op = o; sel = s; DATA = d; serial_in = si;
      x.name = nm; x.sel = s; x.rd0 = x_rd0; x.e0 = x_e0; x.rd1 = x_rd1; x.e1 = x_e1;
      x.chk_e1 = ce1; x.chk_a = ca; x.a0 = xa0; x.zz0 = xz0; x.a1 = xa1;
      sb.push_back(x);
   endtask

   initial begin
      reset = 1'b1; op = 3'b000; sel = 2'd0; DATA = '0; serial_in = 1'b0;
      #1;
      cmp("por A0", A0, 64'h0005_0005_0005_0005);
      cmp("por E0", 64'(E0), 64'h0);
      cmp("por zero0", 64'(z0), 64'h0);
      cmp("por A1", 64'(A1), 64'h0005_0005_0005);
      repeat (2) @(negedge clock);
      reset = 1'b0;

      step("ld2", 3'b001, 2'd2, 16'h1234, 1'b0, 16'h1234, 1'b0, 16'h1234, 1'b0, 1'b1);

      // Asynchronous reset asserted between edges.
      @(negedge clock);
      op = 3'b000;
      #2 reset = 1'b1;
      #1;
      cmp("async rst A0", A0, 64'h0005_0005_0005_0005);
      cmp("async rst E0", 64'(E0), 64'h0);
      cmp("async rst rd0", 64'(rd0), 64'h0005);
      cmp("async rst A1", 64'(A1), 64'h0005_0005_0005);
      @(negedge clock);
      reset = 1'b0;

      step("ld beef", 3'b001, 2'd2, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0, 1'b1,
           1'b1, 64'h0005_BEEF_0005_0005, 4'b0000, 48'hBEEF_0005_0005);
      step("ld ffff", 3'b001, 2'd0, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 1'b1);
      step("inc max", 3'b010, 2'd0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b1,
           1'b1, 64'h0005_BEEF_0005_0000, 4'b0001, 48'hBEEF_0005_FFFF);
      step("ld 0001", 3'b001, 2'd0, 16'h0001, 1'b0, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b1);
      step("inc 1", 3'b010, 2'd0, 16'h0000, 1'b0, 16'h0002, 1'b0, 16'h0002, 1'b0, 1'b1);
      step("ld1 0", 3'b001, 2'd1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
      step("dec 0", 3'b011, 2'd1, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b1);
      step("ld1 1", 3'b001, 2'd1, 16'h0001, 1'b0, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b1);
      step("dec 1", 3'b011, 2'd1, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1,
           1'b1, 64'h0005_BEEF_0000_0002, 4'b0010, 48'hBEEF_0000_0002);

      // Channel 3: a shift chain on dut0. For dut1 sel=3 is out of range.
      step("ld3 8001", 3'b001, 2'd3, 16'h8001, 1'b0, 16'h8001, 1'b0, 16'h0000, 1'b0, 1'b0,
           1'b1, 64'h8001_BEEF_0000_0002, 4'b0010, 48'hBEEF_0000_0002);
      step("shl", 3'b101, 2'd3, 16'h0000, 1'b0, 16'h0002, 1'b1, 16'h0000, 1'b0, 1'b0);
      step("shr si1", 3'b110, 2'd3, 16'h0000, 1'b1, 16'h8001, 1'b0, 16'h0000, 1'b0, 1'b0);
      step("cmpl", 3'b111, 2'd3, 16'h0000, 1'b0, 16'h7FFE, 1'b0, 16'h0000, 1'b0, 1'b0);
      step("shr si0", 3'b110, 2'd3, 16'h0000, 1'b0, 16'h3FFF, 1'b0, 16'h0000, 1'b0, 1'b0);
      step("ld3 8000", 3'b001, 2'd3, 16'h8000, 1'b0, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0);
      step("shl out1", 3'b101, 2'd3, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0);
      step("cmpl e1", 3'b111, 2'd3, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b0);
      step("ld keeps e", 3'b001, 2'd3, 16'h1234, 1'b0, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b0);
      step("hold", 3'b000, 2'd3, 16'h5555, 1'b1, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b0);
      step("clear", 3'b100, 2'd3, 16'h5555, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0,
           1'b1, 64'h0000_BEEF_0000_0002, 4'b1010, 48'hBEEF_0000_0002);

      // Combinational read: rd_data follows sel with no edge in between.
      @(negedge clock);
      op = 3'b000; sel = 2'd2;
      #1;
      cmp("comb rd0 sel2", 64'(rd0), 64'hBEEF);
      cmp("comb rd1 sel2", 64'(rd1), 64'hBEEF);
      sel = 2'd3;
      #1;
      cmp("comb rd1 sel3", 64'(rd1), 64'h0000);
      cmp("comb rd0 sel3", 64'(rd0), 64'h0000);

      // Reset shares a cycle with an inc on ch0; the inc must be lost.
      @(negedge clock);
      op = 3'b010; sel = 2'd0;
      #3 reset = 1'b1;
      @(posedge clock);
      #1;
      cmp("rst+inc rd0", 64'(rd0), 64'h0005);
      cmp("rst+inc A0", A0, 64'h0005_0005_0005_0005);
      cmp("rst+inc rd1", 64'(rd1), 64'h0005);
      @(negedge clock);
      reset = 1'b0; op = 3'b000;

      step("inc after rst", 3'b010, 2'd0, 16'h0000, 1'b0, 16'h0006, 1'b0, 16'h0006, 1'b0, 1'b1);
      @(negedge clock);
      op = 3'b000;

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
      if (sb.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
